ramp_wavegen: RTL and testbench
===============================

# ramp_wavegen

Parametrised successor to the fixed 16-bit free-running ramp generator. Produces a registered sawtooth-up, sawtooth-down, triangle or held waveform between programmable low/high limits with a programmable step. A valid/ready configuration port loads new settings glitch-free at period boundaries. Out of reset it reproduces the original behaviour: a 0..2^WIDTH-1 up-ramp with step 1.

## Interface
- WIDTH, 16, waveform sample width
- STEP_W, 8, step magnitude width (STEP_W <= WIDTH)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance waveform this cycle
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_mode  in  2  0 UP, 1 DOWN, 2 TRI, 3 HOLD
- cfg_step  in  STEP_W  unsigned increment per enabled cycle
- cfg_lo  in  WIDTH  lower limit, unsigned
- cfg_hi  in  WIDTH  upper limit, unsigned
- ramp  out  WIDTH  registered waveform sample
- wrap  out  1  one-cycle pulse at end of period
- cfg_err  out  1  one-cycle pulse when an accepted config is rejected

## Operation
- Active config (mode, step, lo, hi) resets to UP, 1, 0, all-ones. Shadow config holds one pending load.
- Handshake: transfer when cfg_valid && cfg_ready at a rising edge. cfg_ready = !pending. A transfer with cfg_lo > cfg_hi, or with an unsupported mode, is rejected: it pulses cfg_err next cycle, sets no pending load and leaves the active config unchanged.
- Apply rule: a pending load applies on the first edge where en=0, or on the first edge where en=1 and a wrap event occurs. On apply: ramp <= lo (UP, TRI, HOLD) or hi (DOWN), triangle direction <= up, pending cleared. The apply replaces that edge's normal update.
- Arithmetic uses WIDTH+1-bit unsigned intermediates. No silent modular overflow.
- UP: if ramp+step > hi, ramp <= lo and wrap event; else ramp <= ramp+step.
- DOWN: if ramp < lo+step, ramp <= hi and wrap event; else ramp <= ramp-step.
- TRI (dir flag):
  - Up phase: if ramp+step >= hi, ramp <= hi and dir <= down; else add step.
  - Down phase: if ramp <= lo+step, ramp <= lo, dir <= up and wrap event; else subtract step.
- HOLD: ramp unchanged; no wrap.
- step = 0 in any mode: ramp unchanged; no wrap. A pending load therefore applies only when en=0.
- lo = hi: UP/DOWN wrap on every enabled cycle with step >= 1; TRI holds at lo and pulses wrap every second enabled cycle.
- en=0: ramp, dir and wrap hold, except for applying a pending config.

## Timing
- Reset (async assert): ramp=0, wrap=0, cfg_err=0, cfg_ready=1, dir=up, pending cleared, active config at reset values.
- Reset release: the first enabled edge produces ramp=1.
- ramp updates one edge after en is sampled high. wrap is registered and high in the same cycle that ramp shows the reload value.
- Config latency with en=0: accepted at edge N, cfg_ready=0 after N, applied at N+1, cfg_ready=1 after N+1.
- Simultaneous cfg transfer and wrap event on one edge: the wrap uses the old config; the new config is pending.
- Reset mid-operation discards any pending config.

## Configuration
- RAMP_WAVEGEN_TRI_EN defined: mode 2 (TRI) and the dir flag are compiled in.
- Not defined: no dir flag. A transfer with cfg_mode=2 is rejected via cfg_err. Modes 0, 1 and 3 are unaffected.

## Structure
- Shared package ramp_pkg: mode encodings (MODE_UP, MODE_DOWN, MODE_TRI, MODE_HOLD), the config struct typedef, and reset-default constants.
- One sub-module, ramp_cfg_shadow: valid/ready capture, lo>hi/mode validation, pending flag, cfg_err pulse. It hands an apply-ready config to the datapath.

## Test plan
- Reset, en=1 for 70000 cycles, WIDTH=16: ramp counts 0,1,2…65535,0; wrap high only in the cycle ramp=0 after 65535.
- en=0, load UP step=3 lo=10 hi=20, then en=1: ramp 10,13,16,19,10; wrap with the second 10.
- With en=1, load DOWN step=5 lo=0 hi=12 while UP runs with step=1 lo=0 hi=7: old ramp continues to 7. At its wrap edge ramp=12, followed by 7, 2, 12; cfg_ready stays low until that apply.
- TRI step=4 lo=2 hi=11 (macro defined): ramp 2,6,10,11,7,3,2,6; wrap with the second 2. Macro undefined: same load pulses cfg_err; config unchanged.
- cfg_lo=9, cfg_hi=4: cfg_err pulses one cycle; ramp unaffected; cfg_ready stays 1.
- Assert rst asynchronously mid-period with a config pending: ramp=0 immediately. After release with en=1, ramp follows the default up-ramp 1,2,3 and the pending config is never applied.

Source files
------------

// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp waveform generator: mode encodings, config record, reset defaults.
// Config fields are carried at CFG_W bits, so WIDTH must stay below CFG_W.
package ramp_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    typedef struct packed {
        mode_t            mode;
        logic [CFG_W-1:0] step;
        logic [CFG_W-1:0] lo;
        logic [CFG_W-1:0] hi;
    } cfg_t;

    localparam mode_t            DEF_MODE = MODE_UP;
    localparam logic [CFG_W-1:0] DEF_STEP = CFG_W'(1);
    localparam logic [CFG_W-1:0] DEF_LO   = '0;
    localparam logic             DIR_UP   = 1'b0;
    localparam logic             DIR_DOWN = 1'b1;

    function automatic cfg_t default_cfg(input int width);
        cfg_t c;
        c.mode = DEF_MODE;
        c.step = DEF_STEP;
        c.lo   = DEF_LO;
        c.hi   = (CFG_W'(1) << width) - CFG_W'(1);
        return c;
    endfunction

endpackage

// File: rtl/ramp_cfg_shadow.sv
// Configuration capture for ramp_wavegen: valid/ready handshake, validation and one pending load.
// RAMP_WAVEGEN_TRI_EN decides whether triangle mode is accepted.
module ramp_cfg_shadow
    import ramp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    input  logic              apply,
    output logic              pending,
    output cfg_t              shadow,
    output logic              cfg_err
);

`ifdef RAMP_WAVEGEN_TRI_EN
    localparam logic TRI_OK = 1'b1;
`else
    localparam logic TRI_OK = 1'b0;
`endif

    logic take;
    logic cfg_ok;

    assign cfg_ready = !pending;
    assign take      = cfg_valid && !pending;
    assign cfg_ok    = (cfg_lo <= cfg_hi) && ((mode_t'(cfg_mode) != MODE_TRI) || TRI_OK);

    // A rejected transfer only raises cfg_err; shadow and pending stay untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            cfg_err <= 1'b0;
            shadow  <= default_cfg(WIDTH);
        end else begin
            cfg_err <= take && !cfg_ok;
            if (take && cfg_ok) begin
                pending     <= 1'b1;
                shadow.mode <= mode_t'(cfg_mode);
                shadow.step <= CFG_W'(cfg_step);
                shadow.lo   <= CFG_W'(cfg_lo);
                shadow.hi   <= CFG_W'(cfg_hi);
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ramp_wavegen.sv
// Programmable sawtooth/triangle/hold waveform generator with glitch-free config loads at period ends.
// Triangle mode and its direction flag exist only when RAMP_WAVEGEN_TRI_EN is defined.
module ramp_wavegen
    import ramp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    output logic [WIDTH-1:0]  ramp,
    output logic              wrap,
    output logic              cfg_err
);

    cfg_t             act;
    cfg_t             shd;
    logic             pending;
    logic             apply;
    logic             wrap_evt;
    logic [WIDTH-1:0] nxt_ramp;
    logic [CFG_W-1:0] r_x;
    logic [CFG_W-1:0] up_sum;
    logic [CFG_W-1:0] lo_step;
`ifdef RAMP_WAVEGEN_TRI_EN
    logic             dir;
    logic             nxt_dir;
`endif

    ramp_cfg_shadow #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_step  (cfg_step),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .apply     (apply),
        .pending   (pending),
        .shadow    (shd),
        .cfg_err   (cfg_err)
    );

    // Wide intermediates keep ramp+step and lo+step free of modular wrap.
    assign r_x     = CFG_W'(ramp);
    assign up_sum  = r_x + act.step;
    assign lo_step = act.lo + act.step;

    always_comb begin
        nxt_ramp = ramp;
        wrap_evt = 1'b0;
`ifdef RAMP_WAVEGEN_TRI_EN
        nxt_dir  = dir;
`endif
        if (act.step != '0) begin
            case (act.mode)
                MODE_UP: begin
                    if (up_sum > act.hi) begin
                        nxt_ramp = WIDTH'(act.lo);
                        wrap_evt = 1'b1;
                    end else begin
                        nxt_ramp = WIDTH'(up_sum);
                    end
                end
                MODE_DOWN: begin
                    if (r_x < lo_step) begin
                        nxt_ramp = WIDTH'(act.hi);
                        wrap_evt = 1'b1;
                    end else begin
                        nxt_ramp = WIDTH'(r_x - act.step);
                    end
                end
`ifdef RAMP_WAVEGEN_TRI_EN
                MODE_TRI: begin
                    if (dir == DIR_UP) begin
                        if (up_sum >= act.hi) begin
                            nxt_ramp = WIDTH'(act.hi);
                            nxt_dir  = DIR_DOWN;
                        end else begin
                            nxt_ramp = WIDTH'(up_sum);
                        end
                    end else begin
                        if (r_x <= lo_step) begin
                            nxt_ramp = WIDTH'(act.lo);
                            nxt_dir  = DIR_UP;
                            wrap_evt = 1'b1;
                        end else begin
                            nxt_ramp = WIDTH'(r_x - act.step);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // A pending load waits for an idle cycle or the end of the current period.
    assign apply = pending && (!en || wrap_evt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp <= '0;
            wrap <= 1'b0;
            act  <= default_cfg(WIDTH);
`ifdef RAMP_WAVEGEN_TRI_EN
            dir  <= DIR_UP;
`endif
        end else begin
            if (en)
                wrap <= wrap_evt;
            if (apply) begin
                act  <= shd;
                ramp <= (shd.mode == MODE_DOWN) ? WIDTH'(shd.hi) : WIDTH'(shd.lo);
`ifdef RAMP_WAVEGEN_TRI_EN
                dir  <= DIR_UP;
`endif
            end else if (en) begin
                ramp <= nxt_ramp;
`ifdef RAMP_WAVEGEN_TRI_EN
                dir  <= nxt_dir;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ramp_wavegen.sv
// Directed self-checking bench for ramp_wavegen (default WIDTH=16, STEP_W=8).
module tb_ramp_wavegen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_lo;
    logic [15:0] cfg_hi;
    logic [15:0] ramp;
    logic        wrap;
    logic        cfg_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] held;

    ramp_wavegen #(.WIDTH(16), .STEP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_step  (cfg_step),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .ramp      (ramp),
        .wrap      (wrap),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input logic [7:0] s, input logic [15:0] l, input logic [15:0] h);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_step  = s;
        cfg_lo    = l;
        cfg_hi    = h;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 2'd0; cfg_step = 8'd0; cfg_lo = 16'd0; cfg_hi = 16'd0;
        #12;
        checks++; if (ramp !== 16'd0) begin errors++; $display("FAIL reset_ramp got %0d want 0", ramp); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (ramp !== 16'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", ramp); end
    endtask

    task automatic test_free_run();
        logic [15:0] er;
        logic        ew;
        en = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            tick();
            er = 16'(i % 65536);
            ew = (i == 65536);
            checks++;
            if (ramp !== er || wrap !== ew) begin
                errors++;
                $display("FAIL free_run cyc %0d got ramp %0d wrap %b want ramp %0d wrap %b", i, ramp, wrap, er, ew);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_up();
        logic [15:0] er [4] = '{16'd13, 16'd16, 16'd19, 16'd10};
        logic        ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        offer(2'd0, 8'd3, 16'd10, 16'd20);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL up_ready_low got %b want 0", cfg_ready); end
        checks++; if (ramp !== 16'd1) begin errors++; $display("FAIL up_pre_apply got %0d want 1", ramp); end
        tick();
        checks++; if (ramp !== 16'd10 || cfg_ready !== 1'b1) begin errors++; $display("FAIL up_apply got ramp %0d ready %b want 10 1", ramp, cfg_ready); end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ramp !== er[i] || wrap !== ew[i]) begin
                errors++;
                $display("FAIL up_seq %0d got ramp %0d wrap %b want ramp %0d wrap %b", i, ramp, wrap, er[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] er [4] = '{16'd12, 16'd7, 16'd2, 16'd12};
        logic        ew [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        offer(2'd0, 8'd1, 16'd0, 16'd7);
        tick();
        checks++; if (ramp !== 16'd0) begin errors++; $display("FAIL b2b_apply got %0d want 0", ramp); end
        en = 1'b1;
        tick();
        tick();
        offer(2'd1, 8'd5, 16'd0, 16'd12);
        checks++; if (ramp !== 16'd3 || cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_xfer got ramp %0d ready %b want 3 0", ramp, cfg_ready); end
        for (int v = 4; v <= 7; v++) begin
            tick();
            checks++;
            if (ramp !== 16'(v) || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_old got ramp %0d ready %b want %0d 0", ramp, cfg_ready, v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ramp !== er[i] || wrap !== ew[i] || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_new %0d got ramp %0d wrap %b ready %b want %0d %b 1", i, ramp, wrap, cfg_ready, er[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_tri();
`ifdef RAMP_WAVEGEN_TRI_EN
        logic [15:0] er [7] = '{16'd6, 16'd10, 16'd11, 16'd7, 16'd3, 16'd2, 16'd6};
        logic        ew [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        offer(2'd2, 8'd4, 16'd2, 16'd11);
        tick();
        checks++; if (ramp !== 16'd2) begin errors++; $display("FAIL tri_apply got %0d want 2", ramp); end
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (ramp !== er[i] || wrap !== ew[i]) begin
                errors++;
                $display("FAIL tri_seq %0d got ramp %0d wrap %b want ramp %0d wrap %b", i, ramp, wrap, er[i], ew[i]);
            end
        end
        en = 1'b0;
        held = 16'd6;
`else
        offer(2'd2, 8'd4, 16'd2, 16'd11);
        checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL tri_reject got err %b ready %b want 1 1", cfg_err, cfg_ready); end
        tick();
        checks++; if (cfg_err !== 1'b0 || ramp !== 16'd12) begin errors++; $display("FAIL tri_reject_after got err %b ramp %0d want 0 12", cfg_err, ramp); end
        en = 1'b1;
        tick();
        checks++; if (ramp !== 16'd7) begin errors++; $display("FAIL tri_cfg_kept got %0d want 7", ramp); end
        en = 1'b0;
        held = 16'd7;
`endif
    endtask

    task automatic test_bad_range();
        offer(2'd0, 8'd1, 16'd9, 16'd4);
        checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL range_err got err %b ready %b want 1 1", cfg_err, cfg_ready); end
        checks++; if (ramp !== held) begin errors++; $display("FAIL range_ramp got %0d want %0d", ramp, held); end
        tick();
        checks++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || ramp !== held) begin errors++; $display("FAIL range_after got err %b ready %b ramp %0d want 0 1 %0d", cfg_err, cfg_ready, ramp, held); end
    endtask

    task automatic test_reset_pending();
        en = 1'b1;
        offer(2'd0, 8'd2, 16'd100, 16'd200);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending got ready %b want 0", cfg_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ramp !== 16'd0 || cfg_ready !== 1'b1 || wrap !== 1'b0) begin errors++; $display("FAIL rstp_async got ramp %0d ready %b wrap %b want 0 1 0", ramp, cfg_ready, wrap); end
        #1 rst = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            tick();
            checks++;
            if (ramp !== 16'(v) || wrap !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstp_seq got ramp %0d wrap %b ready %b want %0d 0 1", ramp, wrap, cfg_ready, v);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_lo_eq_hi();
        offer(2'd0, 8'd1, 16'd5, 16'd5);
        tick();
        checks++; if (ramp !== 16'd5) begin errors++; $display("FAIL eq_apply got %0d want 5", ramp); end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ramp !== 16'd5 || wrap !== 1'b1) begin
                errors++;
                $display("FAIL eq_wrap %0d got ramp %0d wrap %b want 5 1", i, ramp, wrap);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        held = 16'd0;
        test_reset();
        test_free_run();
        test_load_up();
        test_back_to_back();
        test_tri();
        test_bad_range();
        test_reset_pending();
        test_lo_eq_hi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
